hqm_system_mem_rf_pg_ctl: RTL



---
 rtl/hqm_mem_pg_pkg.sv | 19 +
 rtl/hqm_mem_pg_fsm.sv | 75 +++++++
 rtl/hqm_system_mem_rf_pg_ctl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hqm_mem_pg_pkg.sv
// Shared types and helpers for the power-gated register-file controller.
package hqm_mem_pg_pkg;

  typedef enum logic [2:0] {
    PG_OFF,
    PG_UP,
    PG_ON,
    PG_DRAIN,
    PG_DOWN
  } pg_state_e;

  // Widest word the parity helper covers; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned PAR_MAX_W = 256;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/hqm_mem_pg_fsm.sv
// Power-gating sequencer: OFF -> UP -> ON -> DRAIN -> DOWN with a shared settle/drain counter.
module hqm_mem_pg_fsm
  import hqm_mem_pg_pkg::*;
#(
  parameter int unsigned RD_PIPE    = 0,
  parameter int unsigned PWR_UP_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr_req,
  input  logic pwr_enable_b_in,
  output logic pwr_ack,
  output logic pgcb_isol_en,
  output logic pwr_enable_b,
  output logic clr_vld
);

  localparam int unsigned UP_LAST = PWR_UP_CYC - 1;
  localparam int unsigned CNT_SAT = (UP_LAST > RD_PIPE) ? UP_LAST : RD_PIPE;
  localparam int unsigned CW      = (CNT_SAT < 2) ? 1 : $clog2(CNT_SAT + 1);

  pg_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pwr_req_q;

  // pwr_req comes from another agent, so it is registered once before the FSM acts on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PG_OFF;
      cnt       <= '0;
      pwr_req_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pwr_req_q <= pwr_req;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt == CW'(CNT_SAT)) ? cnt : cnt + 1'b1;
    pwr_ack      = 1'b0;
    pgcb_isol_en = 1'b1;
    pwr_enable_b = 1'b1;
    unique case (state)
      PG_OFF: begin
        cnt_nxt = '0;
        if (pwr_req_q) state_nxt = PG_UP;
      end
      PG_UP: begin
        pwr_enable_b = 1'b0;
        if (!pwr_req_q) state_nxt = PG_DOWN;
        else if (cnt >= CW'(UP_LAST) && !pwr_enable_b_in) state_nxt = PG_ON;
      end
      PG_ON: begin
        pwr_enable_b = 1'b0;
        pgcb_isol_en = 1'b0;
        pwr_ack      = 1'b1;
        cnt_nxt      = '0;
        if (!pwr_req_q) state_nxt = PG_DRAIN;
      end
      PG_DRAIN: begin
        pwr_enable_b = 1'b0;
        pgcb_isol_en = 1'b0;
        if (cnt >= CW'(RD_PIPE)) state_nxt = PG_DOWN;
      end
      PG_DOWN: begin
        if (pwr_enable_b_in) state_nxt = PG_OFF;
      end
      default: state_nxt = PG_OFF;
    endcase
    clr_vld = (state_nxt == PG_DOWN) && (state != PG_DOWN);
  end

endmodule

// File: rtl/hqm_system_mem_rf_pg_ctl.sv
// Power-gated register file with per-word parity and valid bits, gated by the power sequencer.
module hqm_system_mem_rf_pg_ctl
  import hqm_mem_pg_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WIDTH      = 21,
  parameter int unsigned RD_PIPE    = 0,
  parameter int unsigned PWR_UP_CYC = 4,
  localparam int unsigned AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rpar_err,
  output logic             rinv,
  output logic             access_err,
  input  logic             pwr_req,
  output logic             pwr_ack,
  output logic             pgcb_isol_en,
  output logic             pwr_enable_b,
  input  logic             pwr_enable_b_in
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] vld_q;
  logic             clr_vld;
  logic             w_in, r_in, wr_ok, rd_ok;
  logic [WIDTH-1:0] rd_data_c;
  logic             rd_perr_c, rd_inv_c;
  logic             s1_vld, s1_perr, s1_inv;
  logic [WIDTH-1:0] s1_data;

  hqm_mem_pg_fsm #(
    .RD_PIPE    (RD_PIPE),
    .PWR_UP_CYC (PWR_UP_CYC)
  ) u_fsm (
    .clk             (clk),
    .rst             (rst),
    .pwr_req         (pwr_req),
    .pwr_enable_b_in (pwr_enable_b_in),
    .pwr_ack         (pwr_ack),
    .pgcb_isol_en    (pgcb_isol_en),
    .pwr_enable_b    (pwr_enable_b),
    .clr_vld         (clr_vld)
  );

  assign w_in  = {1'b0, waddr} < DEPTH_W;
  assign r_in  = {1'b0, raddr} < DEPTH_W;
  assign wr_ok = pwr_ack && we && w_in;
  assign rd_ok = pwr_ack && re;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[waddr] <= wdata;
  end

  // Out-of-range and never-written words both read back as an invalid, zero word.
  always_comb begin
    rd_data_c = '0;
    rd_perr_c = 1'b0;
    rd_inv_c  = 1'b1;
    if (r_in && vld_q[raddr]) begin
      rd_data_c = mem[raddr];
      rd_perr_c = even_par(PAR_MAX_W'(mem[raddr])) ^ par_q[raddr];
      rd_inv_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      par_q      <= '0;
      access_err <= 1'b0;
      s1_vld     <= 1'b0;
      s1_data    <= '0;
      s1_perr    <= 1'b0;
      s1_inv     <= 1'b0;
    end else begin
      if (clr_vld) begin
        vld_q <= '0;
      end else if (wr_ok) begin
        vld_q[waddr] <= 1'b1;
        par_q[waddr] <= even_par(PAR_MAX_W'(wdata));
      end
      access_err <= ((we || re) && !pwr_ack) ||
                    (pwr_ack && we && !w_in) || (pwr_ack && re && !r_in);
      s1_vld <= rd_ok;
      if (rd_ok) begin
        s1_data <= rd_data_c;
        s1_perr <= rd_perr_c;
        s1_inv  <= rd_inv_c;
      end
    end
  end

  if (RD_PIPE == 0) begin : g_no_pipe
    assign rvalid   = s1_vld;
    assign rdata    = s1_data;
    assign rpar_err = s1_perr;
    assign rinv     = s1_inv;
  end else begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid   <= 1'b0;
        rdata    <= '0;
        rpar_err <= 1'b0;
        rinv     <= 1'b0;
      end else begin
        rvalid <= s1_vld;
        if (s1_vld) begin
          rdata    <= s1_data;
          rpar_err <= s1_perr;
          rinv     <= s1_inv;
        end
      end
    end
  end

endmodule
